// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the phased control unit and its decoder
package ctrl_pkg;
  localparam logic [1:0] CL_LD  = 2'b00;
  localparam logic [1:0] CL_ST  = 2'b01;
  localparam logic [1:0] CL_BR  = 2'b10;
  localparam logic [1:0] CL_ALU = 2'b11;
  localparam logic [3:0] F_IN  = 4'b1100;
  localparam logic [3:0] F_HLT = 4'b1111;
  localparam logic [1:0] F_SHIFT = 2'b10;
  localparam logic [2:0] BC_BE  = 3'd0;
  localparam logic [2:0] BC_BLT = 3'd1;
  localparam logic [2:0] BC_BLE = 3'd2;
  localparam logic [2:0] BC_BNE = 3'd3;
  localparam logic [1:0] SRC_A_LINK  = 2'b01;
  localparam logic [1:0] SRC_B_NONE  = 2'b00;
  localparam logic [1:0] SRC_B_SHIFT = 2'b01;
  localparam logic [1:0] SRC_B_IN    = 2'b10;
  localparam logic [1:0] SRC_B_REG   = 2'b11;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_P1 = 3'd1, ST_P2 = 3'd2, ST_P3 = 3'd3,
    ST_P4 = 3'd4, ST_P5 = 3'd5, ST_HALT = 3'd7
  } state_t;
  typedef struct packed {
    logic       branch;
    logic       mdr;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_op;
    logic       hlt;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
  } ctrl_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: raw (ungated) control lines from the latched IR and condition codes
module ctrl_decode import ctrl_pkg::*; #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic [DATA_W-1:0]     ir,
  input  logic [3:0]            cond,
  output ctrl_t                 ctl,
  output logic [REG_ADDR_W-1:0] rs,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [REG_ADDR_W-1:0] address_for_write
);
  logic [1:0] cls;
  logic [3:0] func;
  logic [2:0] bcond;
  logic       s, z, v, taken, link;
  logic       unused_ok;
  assign cls   = ir[DATA_W-1:DATA_W-2];
  assign func  = ir[7:4];
  assign bcond = ir[DATA_W-3 -: 3];
  assign s = cond[3];
  assign z = cond[2];
  assign v = cond[0];
  assign unused_ok = ^{ir, cond[1]};
  assign rs = ir[DATA_W-3 -: REG_ADDR_W];
  assign rd = ir[DATA_W-3-REG_ADDR_W -: REG_ADDR_W];
  assign address_for_write = cls == CL_LD ? rs : rd;
  assign taken = bcond == BC_BE  ? z :
                 bcond == BC_BLT ? s ^ v :
                 bcond == BC_BLE ? z | (s ^ v) :
                 bcond == BC_BNE ? ~z : 1'b0;
  assign link = cls == CL_BR && bcond == BC_BE;
  always_comb begin
    ctl            = '0;
    ctl.branch     = cls == CL_BR && taken;
    ctl.mdr        = cls == CL_LD;
    ctl.mem_read   = cls == CL_LD;
    ctl.mem_write  = cls == CL_ST;
    ctl.mem_to_reg = cls == CL_LD || (cls == CL_ALU && func == F_IN);
    ctl.reg_write  = ctl.mem_to_reg || link;
    ctl.mem_op     = ~cls[1];
    ctl.hlt        = cls == CL_ALU && func == F_HLT;
    ctl.alu_src_a  = link ? SRC_A_LINK : cls;
    ctl.alu_src_b  = cls != CL_ALU ? SRC_B_NONE :
                     func[3:2] == F_SHIFT ? SRC_B_SHIFT :
                     func == F_IN ? SRC_B_IN : SRC_B_REG;
  end
endmodule

// File: rtl/control_unit_param.sv
// control_unit_param: five-phase sequencer with stall, memory wait states, halt and phase-gated controls
module control_unit_param import ctrl_pkg::*; #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int COND_W     = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     instruction_wire,
  input  logic [DATA_W-1:0]     data_wire,
  input  logic [COND_W-1:0]     cond_wire,
  input  logic [DATA_W-1:0]     mdr_wire,
  input  logic                  stall,
  input  logic                  mem_ready,
  output logic [2:0]            state,
  output logic                  mem_wait,
  output logic                  halted,
  output logic                  op_branch,
  output logic [DATA_W-1:0]     branch_address,
  output logic [REG_ADDR_W-1:0] rs,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [1:0]            op_alu_src_a,
  output logic [1:0]            op_alu_src_b,
  output logic                  op_mdr,
  output logic                  op_mem_read,
  output logic                  op_mem_write,
  output logic [REG_ADDR_W-1:0] address_for_write,
  output logic                  op_mem_to_reg,
  output logic                  op_reg_write
);
  state_t              state_q, state_d;
  logic [DATA_W-1:0]   ir_q, ir_d, data_q, data_d, mdr_q, mdr_d;
  logic [COND_W-1:0]   cond_q, cond_d;
  ctrl_t               ctl;
  logic                active, p25, p4, p5, go;
  logic                unused_ok;
  ctrl_decode #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_dec (
    .ir(ir_q), .cond(cond_q[3:0]), .ctl(ctl),
    .rs(rs), .rd(rd), .address_for_write(address_for_write)
  );
  assign go = ~stall;
  always_comb begin
    state_d = state_q;
    if (go)
      case (state_q)
        ST_IDLE: state_d = ST_P1;
        ST_P1:   state_d = ST_P2;
        ST_P2:   state_d = ST_P3;
        ST_P3:   state_d = ST_P4;
        ST_P4:   state_d = (ctl.mem_op && !mem_ready) ? ST_P4 : ST_P5;
        ST_P5:   state_d = ctl.hlt ? ST_HALT : ST_P1;
        default: state_d = ST_HALT;
      endcase
    ir_d   = (go && state_q == ST_P1) ? instruction_wire : ir_q;
    data_d = (go && state_q == ST_P3) ? data_wire : data_q;
    cond_d = (go && state_q == ST_P3) ? cond_wire : cond_q;
    mdr_d  = (go && state_q == ST_P4 && mem_ready) ? mdr_wire : mdr_q;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      data_q  <= '0;
      cond_q  <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      data_q  <= data_d;
      cond_q  <= cond_d;
      mdr_q   <= mdr_d;
    end
  // MDR has no consumer on this block's ports; the register file reads it directly
  assign unused_ok = ^{mdr_q, cond_q};
  assign active = state_q inside {ST_P1, ST_P2, ST_P3, ST_P4, ST_P5};
  assign p25    = state_q inside {ST_P2, ST_P3, ST_P4, ST_P5};
  assign p4     = state_q == ST_P4;
  assign p5     = state_q == ST_P5;
  assign state          = state_q;
  assign halted         = state_q == ST_HALT;
  assign mem_wait       = p4 && ctl.mem_op && !mem_ready;
  assign branch_address = data_q;
  assign op_branch      = p5 && ctl.branch;
  assign op_reg_write   = p5 && ctl.reg_write;
  assign op_mdr         = p4 && ctl.mdr;
  assign op_mem_read    = p4 && ctl.mem_read;
  assign op_mem_write   = p4 && ctl.mem_write;
  assign op_mem_to_reg  = active && ctl.mem_to_reg;
  assign op_alu_src_a   = p25 ? ctl.alu_src_a : 2'b00;
  assign op_alu_src_b   = p25 ? ctl.alu_src_b : 2'b00;
endmodule
